// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between NREQ requesters. An idle arbiter
//   grants round-robin, registers the winner's opcode/operands onto the ALU
//   ports for exactly one cycle, captures result and flags, and hands them
//   back to the winner on a valid/ready response channel. Illegal opcodes
//   (1001..1111) never reach the ALU; they get an immediate error response.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot)
//   req_opcode/a/b        packed per-requester opcode (4b) and operands (W)
//   alu_opcode/a/b        registered drive to the ALU, NOP/0 outside EXEC
//   alu_o/alu_flags       combinational ALU result and flags
//   rsp_valid/rsp_ready   per-requester response handshake (valid one-hot)
//   rsp_o/flags/err       captured result, flags, illegal-opcode flag
//   busy                  arbiter is not idle
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NREQ  = 2,
  parameter int W     = 4,
  parameter int FLAGW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*4-1:0]   req_opcode,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [3:0]          alu_opcode,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  input  logic [W-1:0]        alu_o,
  input  logic [FLAGW-1:0]    alu_flags,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [W-1:0]        rsp_o,
  output logic [FLAGW-1:0]    rsp_flags,
  output logic                rsp_err,
  output logic                busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state, w_next_state;
  logic [IW-1:0]    r_ptr, r_gid, w_gid;
  logic             w_any, w_legal, w_accept;
  logic [3:0]       w_op;
  logic [W-1:0]     w_a, w_b;
  logic [3:0]       r_alu_opcode;
  logic [W-1:0]     r_alu_a, r_alu_b;
  logic [W-1:0]     r_rsp_o;
  logic [FLAGW-1:0] r_rsp_flags;
  logic             r_rsp_err;

  // Round-robin search: start just after the last winner and wrap, so the
  // most recent winner has the lowest priority next time.
  always_comb begin : p_grant
    logic [IW-1:0] idx;
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    idx   = '0;
    w_any = 1'b0;
    w_gid = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(r_ptr) + k) % NREQ);
      if (!w_any && req_valid[idx]) begin
        w_any = 1'b1;
        w_gid = idx;
      end
    end
  end

  // Winner's request fields
  always_comb begin : p_sel
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gid == IW'(i)) begin
        w_op = req_opcode[i*4 +: 4];
        w_a  = req_a[i*W +: W];
        w_b  = req_b[i*W +: W];
      end
    end
  end

  assign w_legal  = (w_op <= 4'd8);
  assign w_accept = (r_state == S_IDLE) && w_any;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin : p_next
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next_state = w_legal ? S_EXEC : S_RESP;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (rsp_ready[r_gid]) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs. Grants are only offered while idle, so a response
  // handshake and a new request never overlap in the same cycle.
  always_comb begin : p_out
    req_ready = '0;
    rsp_valid = '0;
    busy      = (r_state != S_IDLE);
    if (w_accept)            req_ready = NREQ'(1) << w_gid;
    if (r_state == S_RESP)   rsp_valid = NREQ'(1) << r_gid;
  end

  // Datapath. The ALU port registers double as the operand latch: loaded
  // only for legal opcodes on accept, cleared when EXEC ends, so the ALU
  // sees NOP/0 in every other cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= IW'(NREQ - 1);
      r_gid        <= '0;
      r_alu_opcode <= 4'b0000;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_o      <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr <= w_gid;
        r_gid <= w_gid;
        if (w_legal) begin
          r_alu_opcode <= w_op;
          r_alu_a      <= w_a;
          r_alu_b      <= w_b;
        end else begin
          r_rsp_o     <= '0;
          r_rsp_flags <= '0;
          r_rsp_err   <= 1'b1;
        end
      end
      if (r_state == S_EXEC) begin
        r_rsp_o      <= alu_o;
        r_rsp_flags  <= alu_flags;
        r_rsp_err    <= 1'b0;
        r_alu_opcode <= 4'b0000;
        r_alu_a      <= '0;
        r_alu_b      <= '0;
      end
    end
  end

  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_o      = r_rsp_o;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter (NREQ=2, W=4, FLAGW=8). A small ALU model
//   drives alu_o/alu_flags. A transaction-level reference (owner, age since
//   accept, round-robin last winner) predicts every output each cycle; the
//   directed tests add hand-computed literal expectations.
//   ALU encoding used here: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LSH(1),
//   7 RSH(1), 8 NOT a, 0 NOP. Flags = {opcode, a^b^result}.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int NREQ  = 2;
  localparam int W     = 4;
  localparam int FLAGW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*4-1:0] req_opcode = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [3:0]        alu_opcode;
  logic [W-1:0]      alu_a, alu_b, alu_o;
  logic [FLAGW-1:0]  alu_flags;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [W-1:0]      rsp_o;
  logic [FLAGW-1:0]  rsp_flags;
  logic              rsp_err;
  logic              busy;

  alu_arbiter #(.NREQ(NREQ), .W(W), .FLAGW(FLAGW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_o(rsp_o), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [FLAGW+W-1:0] alu_fn(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      4'd1:    r = a + b;
      4'd2:    r = a - b;
      4'd3:    r = a & b;
      4'd4:    r = a | b;
      4'd5:    r = a ^ b;
      4'd6:    r = a << 1;
      4'd7:    r = a >> 1;
      4'd8:    r = ~a;
      default: r = '0;
    endcase
    return {op, a ^ b ^ r, r};
  endfunction

  assign {alu_flags, alu_o} = alu_fn(alu_opcode, alu_a, alu_b);

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic bit_of(logic [NREQ-1:0] v, int i);
    return |(v & NREQ'(1 << i));
  endfunction

  function automatic logic [3:0] field4(logic [NREQ*4-1:0] v, int i);
    return 4'(v >> (i * 4));
  endfunction

  function automatic int rr_pick(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (bit_of(v, (last + k) % NREQ)) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  typedef struct {
    int               id;
    logic [W-1:0]     o;
    logic [FLAGW-1:0] f;
    logic             e;
  } rsp_t;

  int   grant_q[$];
  int   acc_cyc_q[$];
  int   rvs_cyc_q[$];
  rsp_t rsp_q[$];
  logic prev_rv     = 1'b0;
  logic alu_touched = 1'b0;

  function automatic int q_at(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic rsp_t rsp_at(int i);
    rsp_t r;
    r.id = -1; r.o = '0; r.f = '0; r.e = 1'b0;
    if (i < rsp_q.size()) r = rsp_q[i];
    return r;
  endfunction

  // Reference model state: who owns the ALU and how many edges since accept.
  int               m_owner = -1;
  int               m_last  = NREQ - 1;
  int               m_age   = 0;
  logic             m_legal = 1'b0;
  logic [3:0]       m_op    = '0;
  logic [W-1:0]     m_a = '0, m_b = '0, m_res = '0;
  logic [FLAGW-1:0] m_flg = '0;
  logic             m_err = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compare against the model, log handshakes, then advance the
  // model with the inputs the DUT will see at the next rising edge.
  initial forever begin
    int              g;
    logic            in_exec, in_resp;
    logic [NREQ-1:0] e_ready, e_rv;
    @(negedge clk);
    if (rst) begin
      m_owner = -1; m_last = NREQ - 1; m_age = 0; prev_rv = 1'b0;
    end else begin
      g       = (m_owner < 0) ? rr_pick(req_valid, m_last) : -1;
      e_ready = (g >= 0) ? NREQ'(1 << g) : '0;
      in_exec = (m_owner >= 0) && m_legal && (m_age == 1);
      in_resp = (m_owner >= 0) && (m_age >= (m_legal ? 2 : 1));
      e_rv    = in_resp ? NREQ'(1 << m_owner) : '0;
      check("mdl_req_ready", 32'(req_ready), 32'(e_ready));
      check("mdl_busy", 32'(busy), 32'(m_owner >= 0));
      check("mdl_alu_opcode", 32'(alu_opcode), in_exec ? 32'(m_op) : 32'd0);
      check("mdl_alu_a", 32'(alu_a), in_exec ? 32'(m_a) : 32'd0);
      check("mdl_alu_b", 32'(alu_b), in_exec ? 32'(m_b) : 32'd0);
      check("mdl_rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (in_resp) begin
        check("mdl_rsp_o", 32'(rsp_o), 32'(m_res));
        check("mdl_rsp_flags", 32'(rsp_flags), 32'(m_flg));
        check("mdl_rsp_err", 32'(rsp_err), 32'(m_err));
      end
      for (int k = 0; k < NREQ; k++) begin
        if (bit_of(req_valid & req_ready, k)) begin
          grant_q.push_back(k);
          acc_cyc_q.push_back(cyc);
        end
        if (bit_of(rsp_valid & rsp_ready, k)) begin
          rsp_t r;
          r.id = k; r.o = rsp_o; r.f = rsp_flags; r.e = rsp_err;
          rsp_q.push_back(r);
        end
      end
      if (rsp_valid != '0 && !prev_rv) rvs_cyc_q.push_back(cyc);
      prev_rv = (rsp_valid != '0);
      if (alu_opcode != 4'd0) alu_touched = 1'b1;

      if (g >= 0) begin
        m_owner = g; m_last = g; m_age = 1;
        m_op = field4(req_opcode, g);
        m_a  = W'(req_a >> (g * W));
        m_b  = W'(req_b >> (g * W));
        m_legal = (m_op <= 4'd8);
        if (m_legal) begin
          {m_flg, m_res} = alu_fn(m_op, m_a, m_b);
          m_err = 1'b0;
        end else begin
          m_res = '0; m_flg = '0; m_err = 1'b1;
        end
      end else if (in_resp && bit_of(rsp_ready, m_owner)) begin
        m_owner = -1;
      end else if (m_owner >= 0 && m_age < 1000) begin
        m_age++;
      end
    end
  end

  task automatic set_req(input int id, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_opcode = (req_opcode & ~((NREQ*4)'(4'hF) << (id * 4))) | ((NREQ*4)'(op) << (id * 4));
    req_a      = (req_a & ~((NREQ*W)'({W{1'b1}}) << (id * W))) | ((NREQ*W)'(a) << (id * W));
    req_b      = (req_b & ~((NREQ*W)'({W{1'b1}}) << (id * W))) | ((NREQ*W)'(b) << (id * W));
  endtask

  task automatic clear_logs();
    grant_q.delete(); acc_cyc_q.delete(); rvs_cyc_q.delete(); rsp_q.delete();
    alu_touched = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_grant(input int id, input int budget);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bit_of(req_ready, id) && t < budget);
    check("grant_wait", 32'(bit_of(req_ready, id)), 32'd1);
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    set_req(id, op, a, b);
    req_valid = req_valid | NREQ'(1 << id);
    wait_grant(id, 20);
    @(posedge clk); #1;
    req_valid = req_valid & ~NREQ'(1 << id);
  endtask

  task automatic wait_rsp_count(input int n, input int budget);
    int t = 0;
    while (rsp_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("rsp_count", 32'(rsp_q.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1);
  end

  initial begin
    rsp_t r;
    int   t;

    // Reset state (rst held high from time 0 across the first edge)
    @(negedge clk);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_o", 32'(rsp_o), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single ADD 1+1
    do_reset();
    rsp_ready = 2'b01;
    issue(0, 4'd1, 4'd1, 4'd1);
    wait_rsp_count(1, 20);
    r = rsp_at(0);
    check("t1_id", 32'(r.id), 32'd0);
    check("t1_rsp_o", 32'(r.o), 32'd2);
    check("t1_rsp_flags", 32'(r.f), 32'h12);
    check("t1_err", 32'(r.e), 32'd0);
    check("t1_latency", 32'(q_at(rvs_cyc_q, 0) - q_at(acc_cyc_q, 0)), 32'd2);

    // 2: contention, XOR from req0 and AND from req1 held valid
    do_reset();
    rsp_ready = 2'b11;
    set_req(0, 4'd5, 4'b1010, 4'b0110);
    set_req(1, 4'd3, 4'b1010, 4'b0110);
    req_valid = 2'b11;
    wait_rsp_count(4, 40);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      r = rsp_at(i);
      check("t2_grant_order", 32'(q_at(grant_q, i)), 32'(i % 2));
      check("t2_rsp_id", 32'(r.id), 32'(i % 2));
      check("t2_rsp_o", 32'(r.o), (i % 2 == 0) ? 32'b1100 : 32'b0010);
    end

    // 3: backpressure on the response channel
    do_reset();
    rsp_ready = 2'b00;
    issue(0, 4'd1, 4'd3, 4'd4);
    t = 0;
    while (rsp_valid == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t3_rsp_seen", 32'(rsp_valid), 32'b01);
    @(posedge clk); #1;
    set_req(1, 4'd2, 4'd9, 4'd1);
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_rsp_valid", 32'(rsp_valid), 32'b01);
      check("t3_rsp_o", 32'(rsp_o), 32'd7);
      check("t3_rsp_flags", 32'(rsp_flags), 32'h10);
      check("t3_req_ready", 32'(req_ready), 32'd0);
      check("t3_alu_opcode", 32'(alu_opcode), 32'd0);
      check("t3_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    @(negedge clk);
    check("t3_other_ready_ignored", 32'(rsp_valid), 32'b01);
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    wait_rsp_count(2, 20);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    r = rsp_at(0);
    check("t3_first_id", 32'(r.id), 32'd0);
    r = rsp_at(1);
    check("t3_second_id", 32'(r.id), 32'd1);
    check("t3_second_o", 32'(r.o), 32'd8);

    // 4: illegal opcode from req1
    do_reset();
    rsp_ready = 2'b11;
    issue(1, 4'b1011, 4'd5, 4'd5);
    wait_rsp_count(1, 20);
    r = rsp_at(0);
    check("t4_id", 32'(r.id), 32'd1);
    check("t4_err", 32'(r.e), 32'd1);
    check("t4_rsp_o", 32'(r.o), 32'd0);
    check("t4_rsp_flags", 32'(r.f), 32'd0);
    check("t4_latency", 32'(q_at(rvs_cyc_q, 0) - q_at(acc_cyc_q, 0)), 32'd1);
    check("t4_alu_untouched", 32'(alu_touched), 32'd0);

    // 5: reset asserted between edges during EXEC
    do_reset();
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    set_req(0, 4'd1, 4'd3, 4'd5);
    set_req(1, 4'd4, 4'd1, 4'd2);
    req_valid = 2'b01;
    wait_grant(0, 20);
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    check("t5_exec_busy", 32'(busy), 32'd1);
    check("t5_exec_alu_opcode", 32'(alu_opcode), 32'd1);
    check("t5_exec_alu_a", 32'(alu_a), 32'd3);
    rst = 1'b1;
    #1;
    check("t5_rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("t5_rst_alu_a", 32'(alu_a), 32'd0);
    check("t5_rst_alu_b", 32'(alu_b), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_rsp_o", 32'(rsp_o), 32'd0);
    check("t5_rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    repeat (3) @(negedge clk);
    check("t5_no_stale_rsp", 32'(rvs_cyc_q.size()), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b11;
    wait_rsp_count(1, 20);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    check("t5_first_grant", 32'(q_at(grant_q, 0)), 32'd0);

    // 6: throughput, RSH then LSH from req0 with rsp_ready high
    do_reset();
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    set_req(0, 4'd7, 4'b0010, 4'd0);
    req_valid = 2'b01;
    wait_grant(0, 20);
    @(posedge clk); #1;
    set_req(0, 4'd6, 4'b0010, 4'd0);
    wait_grant(0, 20);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp_count(2, 20);
    check("t6_first_o", 32'(rsp_at(0).o), 32'b0001);
    check("t6_second_o", 32'(rsp_at(1).o), 32'b0100);
    check("t6_spacing", 32'(q_at(rvs_cyc_q, 1) - q_at(rvs_cyc_q, 0)), 32'd3);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
